// File: rtl/bsg_axil_responder_csr.sv
// AXI-Lite responder exposing num_regs_p byte-strobed CSRs with one-cycle response latency.
// Define BSG_AXIL_RESPONDER_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module bsg_axil_responder_csr #(
  parameter int              addr_width_p = 16,
  parameter int              data_width_p = 32,
  parameter int              num_regs_p   = 4,
  parameter longint unsigned base_addr_p  = 64'h1000
) (
  input  logic                               aclk_i,
  input  logic                               areset_i,
  input  logic [addr_width_p-1:0]            awaddr_i,
  input  logic [2:0]                         awprot_i,
  input  logic                               awvalid_i,
  output logic                               awready_o,
  input  logic [data_width_p-1:0]            wdata_i,
  input  logic [data_width_p/8-1:0]          wstrb_i,
  input  logic                               wvalid_i,
  output logic                               wready_o,
  output logic [1:0]                         bresp_o,
  output logic                               bvalid_o,
  input  logic                               bready_i,
  input  logic [addr_width_p-1:0]            araddr_i,
  input  logic [2:0]                         arprot_i,
  input  logic                               arvalid_i,
  output logic                               arready_o,
  output logic [data_width_p-1:0]            rdata_o,
  output logic [1:0]                         rresp_o,
  output logic                               rvalid_o,
  input  logic                               rready_i,
  output logic [num_regs_p*data_width_p-1:0] csr_data_o,
  output logic [num_regs_p-1:0]              csr_w_v_o
);

  localparam int lanes_lp = data_width_p / 8;
  localparam int lg_lp    = $clog2(lanes_lp);
  localparam int idx_w_lp = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;
  localparam logic [addr_width_p-1:0] base_lp  = addr_width_p'(base_addr_p);
  localparam logic [addr_width_p-1:0] nregs_lp = addr_width_p'(num_regs_p);
`ifdef BSG_AXIL_RESPONDER_SLVERR_EN
  localparam logic [1:0] oor_resp_lp = 2'b10;
`else
  localparam logic [1:0] oor_resp_lp = 2'b00;
`endif

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  logic [num_regs_p-1:0][data_width_p-1:0] csr_q;
  assign csr_data_o = csr_q;

  // Readies stay low through reset and rise on the first edge after it.
  logic rdy_q;
  always_ff @(posedge aclk_i or posedge areset_i)
    if (areset_i) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;

  // ---------------- write path ----------------
  w_state_e w_state_q, w_state_n;
  logic                      aw_held_q, w_held_q;
  logic [addr_width_p-1:0]   aw_addr_q;
  logic [data_width_p-1:0]   wdata_q;
  logic [lanes_lp-1:0]       wstrb_q;
  logic [1:0]                bresp_q;

  logic aw_hs, w_hs, commit, b_hs;
  logic [addr_width_p-1:0] w_addr, w_off, w_word;
  logic [data_width_p-1:0] w_data;
  logic [lanes_lp-1:0]     w_strb;
  logic                    w_hit;
  logic [idx_w_lp-1:0]     w_idx;

  assign awready_o = rdy_q & (w_state_q == W_IDLE) & ~aw_held_q;
  assign wready_o  = rdy_q & (w_state_q == W_IDLE) & ~w_held_q;
  assign aw_hs     = awvalid_i & awready_o;
  assign w_hs      = wvalid_i & wready_o;
  assign commit    = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign b_hs      = (w_state_q == W_RESP) & bready_i;
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bresp_o   = bresp_q;

  // A channel arriving in the commit cycle is used directly rather than from its hold register.
  assign w_addr = aw_held_q ? aw_addr_q : awaddr_i;
  assign w_data = w_held_q  ? wdata_q   : wdata_i;
  assign w_strb = w_held_q  ? wstrb_q   : wstrb_i;
  assign w_off  = w_addr - base_lp;
  assign w_word = w_off >> lg_lp;
  assign w_hit  = (w_addr >= base_lp) && (w_word < nregs_lp);
  assign w_idx  = w_word[idx_w_lp-1:0];

  always_comb begin
    w_state_n = w_state_q;
    case (w_state_q)
      W_IDLE:  if (commit) w_state_n = W_RESP;
      W_RESP:  if (bready_i) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or posedge areset_i)
    if (areset_i) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_n;
      if (b_hs) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end else begin
        if (aw_hs) begin aw_held_q <= 1'b1; aw_addr_q <= awaddr_i; end
        if (w_hs)  begin w_held_q  <= 1'b1; wdata_q <= wdata_i; wstrb_q <= wstrb_i; end
      end
      if (commit) bresp_q <= w_hit ? 2'b00 : oor_resp_lp;
    end

  for (genvar i = 0; i < num_regs_p; i++) begin : g_csr
    assign csr_w_v_o[i] = commit & w_hit & (w_idx == idx_w_lp'(i));
    always_ff @(posedge aclk_i or posedge areset_i)
      if (areset_i) csr_q[i] <= '0;
      else if (csr_w_v_o[i])
        for (int k = 0; k < lanes_lp; k++)
          if (w_strb[k]) csr_q[i][8*k +: 8] <= w_data[8*k +: 8];
  end

  // ---------------- read path ----------------
  r_state_e r_state_q, r_state_n;
  logic [data_width_p-1:0] rdata_q;
  logic [1:0]              rresp_q;
  logic                    ar_hs, r_hit;
  logic [addr_width_p-1:0] r_off, r_word;
  logic [idx_w_lp-1:0]     r_idx;

  assign arready_o = rdy_q & (r_state_q == R_IDLE);
  assign ar_hs     = arvalid_i & arready_o;
  assign rvalid_o  = (r_state_q == R_RESP);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign r_off     = araddr_i - base_lp;
  assign r_word    = r_off >> lg_lp;
  assign r_hit     = (araddr_i >= base_lp) && (r_word < nregs_lp);
  assign r_idx     = r_word[idx_w_lp-1:0];

  always_comb begin
    r_state_n = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_n = R_RESP;
      R_RESP:  if (rready_i) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  // csr_q is sampled before any same-cycle write lands, so a colliding read sees the old value.
  always_ff @(posedge aclk_i or posedge areset_i)
    if (areset_i) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_n;
      if (ar_hs) begin
        rdata_q <= r_hit ? csr_q[r_idx] : '0;
        rresp_q <= r_hit ? 2'b00 : oor_resp_lp;
      end
    end

endmodule
